// File: rtl/n_bit_divider.sv
// n_bit_divider: sequential restoring divider, one quotient bit per clock.
//
// Divides a 2N-bit dividend by an N-bit divisor. It returns a 2N-bit quotient
// and an N-bit remainder. A start/done handshake controls each operation.
//
// Optional feature macro: DIV_SIGNED_EN.
//   Undefined : unsigned operands. Latency is 2N+1 edges from start to the done cycle.
//   Defined   : two's-complement operands. The core divides the magnitudes, then
//               an extra FIX cycle applies the signs. Latency is 2N+2 edges.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset; aborts any operation
//   start        request; sampled only in IDLE or DONE
//   dividend     2N-bit numerator, latched on an accepted start
//   divisor      N-bit denominator, latched on an accepted start
//   busy         high while iterating (and during FIX in signed builds)
//   done         one-cycle pulse; results are valid in that cycle
//   quotient     2N-bit result, held until the next completion
//   remainder    N-bit result, held until the next completion
//   div_by_zero  set together with done when the latched divisor was 0

module n_bit_divider #(
    parameter int unsigned N = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero
);

    localparam int unsigned CW = $clog2(2 * N + 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;
`ifdef DIV_SIGNED_EN
    localparam logic [1:0] StFix  = 2'd3;
`endif

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    // The restored partial remainder is always below the divisor, so N bits
    // are enough to store it. Only the shifted trial value needs N+1 bits.
    logic [N-1:0]   prem_q, prem_d;
    logic [2*N-1:0] shreg_q, shreg_d;
    logic [N-1:0]   dvs_q, dvs_d;
    logic [2*N-1:0] quot_q, quot_d;
    logic [N-1:0]   rem_q, rem_d;
    logic           dbz_q, dbz_d;
`ifdef DIV_SIGNED_EN
    logic           qneg_q, qneg_d;   // quotient negative: operand signs differ
    logic           rneg_q, rneg_d;   // remainder follows the dividend sign
`endif

    logic [N:0]     shifted;
    logic [N:0]     trial;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        prem_d  = prem_q;
        shreg_d = shreg_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif

        shifted = {prem_q, shreg_q[2*N-1]};
        trial   = shifted - {1'b0, dvs_q};

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    if (divisor == '0) begin
                        dvs_d   = divisor;
                        state_d = StDone;
                        quot_d  = '1;
                        rem_d   = '0;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = StRun;
                        count_d = CW'(2 * N);
                        prem_d  = '0;
`ifdef DIV_SIGNED_EN
                        shreg_d = dividend[2*N-1] ? -dividend : dividend;
                        dvs_d   = divisor[N-1] ? -divisor : divisor;
                        qneg_d  = dividend[2*N-1] ^ divisor[N-1];
                        rneg_d  = dividend[2*N-1];
`else
                        shreg_d = dividend;
                        dvs_d   = divisor;
`endif
                    end
                end else begin
                    state_d = StIdle;
                end
            end

            StRun: begin
                if (!trial[N]) begin
                    prem_d  = trial[N-1:0];
                    shreg_d = {shreg_q[2*N-2:0], 1'b1};
                end else begin
                    prem_d  = shifted[N-1:0];
                    shreg_d = {shreg_q[2*N-2:0], 1'b0};
                end
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
`ifdef DIV_SIGNED_EN
                    state_d = StFix;
`else
                    state_d = StDone;
                    quot_d  = shreg_d;
                    rem_d   = prem_d;
                    dbz_d   = 1'b0;
`endif
                end
            end

`ifdef DIV_SIGNED_EN
            StFix: begin
                // Negating the magnitude wraps -2^(2N-1) / -1 to 2^(2N-1).
                state_d = StDone;
                quot_d  = qneg_q ? -shreg_q : shreg_q;
                rem_d   = rneg_q ? -prem_q : prem_q;
                dbz_d   = 1'b0;
            end
`endif

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            count_q <= '0;
            prem_q  <= '0;
            shreg_q <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            prem_q  <= prem_d;
            shreg_q <= shreg_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

`ifdef DIV_SIGNED_EN
    assign busy = (state_q == StRun) || (state_q == StFix);
`else
    assign busy = (state_q == StRun);
`endif
    assign done        = (state_q == StDone);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_n_bit_divider.sv
// Testbench for n_bit_divider.
// The bench keeps an arithmetic model, built on / and %, and a queue of
// expected completions. A compare process checks busy, done timing, results
// and output holding on every falling edge. Directed cases add
// hand-computed literal expectations.
// If DIV_SIGNED_EN is defined, the bench runs the signed cases instead of
// the unsigned edge cases.

module tb_n_bit_divider;

    localparam int N = 8;
`ifdef DIV_SIGNED_EN
    localparam int LAT = 2 * N + 1;
`else
    localparam int LAT = 2 * N;
`endif

    typedef struct {
        logic [2*N-1:0] q;
        logic [N-1:0]   r;
        logic           dbz;
        int             acc;
        int             done_cyc;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic           busy;
    logic           done;
    logic [2*N-1:0] quotient;
    logic [N-1:0]   remainder;
    logic           div_by_zero;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    logic [2*N-1:0] last_q = '0;
    logic [N-1:0]   last_r = '0;
    logic           last_z = 1'b0;

    n_bit_divider #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic exp_t model(input logic [2*N-1:0] dd, input logic [N-1:0] dv);
        exp_t   e;
        longint a, b, qq, rr;
        e.acc = 0;
        e.done_cyc = 0;
        if (dv == '0) begin
            e.q = '1;
            e.r = '0;
            e.dbz = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            a = longint'($signed(dd));
            b = longint'($signed(dv));
`else
            a = longint'(dd);
            b = longint'(dv);
`endif
            qq = a / b;
            rr = a % b;
            e.q = qq[2*N-1:0];
            e.r = rr[N-1:0];
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Per-cycle comparison against the model queue.
    always @(negedge clk) begin
        logic exp_busy;
        exp_t e;
        exp_busy = (exp_q.size() > 0) && (cyc >= exp_q[0].acc) && (cyc < exp_q[0].done_cyc);
        check("busy", 32'(busy), 32'(exp_busy));
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'(done), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("done_cycle", cyc, e.done_cyc);
                check("quotient", 32'(quotient), 32'(e.q));
                check("remainder", 32'(remainder), 32'(e.r));
                check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                last_q = e.q;
                last_r = e.r;
                last_z = e.dbz;
            end
        end else begin
            check("hold_quotient", 32'(quotient), 32'(last_q));
            check("hold_remainder", 32'(remainder), 32'(last_r));
            check("hold_dbz", 32'(div_by_zero), 32'(last_z));
            if (exp_q.size() > 0 && cyc >= exp_q[0].done_cyc) begin
                check("missing_done", 32'(done), 32'(1));
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic issue(input logic [2*N-1:0] dd, input logic [N-1:0] dv, input bit now);
        exp_t e;
        if (!now) @(negedge clk);
        start = 1'b1;
        dividend = dd;
        divisor = dv;
        @(posedge clk);
        #1;
        start = 1'b0;
        e = model(dd, dv);
        e.acc = cyc;
        e.done_cyc = (dv == '0) ? cyc : cyc + LAT;
        exp_q.push_back(e);
        // Operands may change freely once accepted.
        dividend = 16'($urandom);
        divisor = 8'($urandom);
    endtask

    // Raises start while busy; the divider must ignore it.
    task automatic poke(input logic [2*N-1:0] dd, input logic [N-1:0] dv);
        @(negedge clk);
        start = 1'b1;
        dividend = dd;
        divisor = dv;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, output int n_wait, output int n_busy);
        bit seen = 0;
        n_wait = 0;
        n_busy = 0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            n_wait++;
            if (busy === 1'b1) n_busy++;
            if (done === 1'b1) seen = 1;
        end
        if (!seen) check("done_timeout", 32'(0), 32'(1));
    endtask

    task automatic lit(input string name, input logic [2*N-1:0] q, input logic [N-1:0] r,
                       input logic z);
        check({name, "_q"}, 32'(quotient), 32'(q));
        check({name, "_r"}, 32'(remainder), 32'(r));
        check({name, "_z"}, 32'(div_by_zero), 32'(z));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nw, nb, acc;
        reset = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        lit("rst", 16'h0000, 8'h00, 1'b0);
        #2 reset = 1'b0;

`ifndef DIV_SIGNED_EN
        issue(16'hC350, 8'hC8, 0);
        wait_done(40, nw, nb);
        lit("c350_c8", 16'h00FA, 8'h00, 1'b0);
        check("c350_busy_cycles", nb, 16);
        check("c350_latency", nw, 17);

        issue(16'd1000, 8'd7, 0);
        wait_done(40, nw, nb);
        lit("1000_7", 16'h008E, 8'h06, 1'b0);

        issue(16'hFFFF, 8'h01, 0);
        wait_done(40, nw, nb);
        lit("ffff_1", 16'hFFFF, 8'h00, 1'b0);

        issue(16'h00FE, 8'hFF, 0);
        wait_done(40, nw, nb);
        lit("fe_ff", 16'h0000, 8'hFE, 1'b0);
`else
        issue(16'hFC18, 8'h07, 0);
        wait_done(40, nw, nb);
        lit("m1000_7", 16'hFF72, 8'hFA, 1'b0);
        check("s_latency", nw, 18);

        issue(16'd1000, 8'hF9, 0);
        wait_done(40, nw, nb);
        lit("1000_m7", 16'hFF72, 8'h06, 1'b0);
        check("s_busy_cycles", nb, 17);

        issue(16'h8000, 8'hFF, 0);
        wait_done(40, nw, nb);
        lit("ovf", 16'h8000, 8'h00, 1'b0);
        check("ovf_latency", nw, 18);
`endif

        // Divide by zero completes in the cycle right after the accepting edge.
        issue(16'h04D2, 8'h00, 0);
        wait_done(40, nw, nb);
        lit("dbz", 16'hFFFF, 8'h00, 1'b1);
        check("dbz_latency", nw, 1);
        issue(16'd10, 8'd3, 0);
        wait_done(40, nw, nb);
        lit("10_3", 16'h0003, 8'h01, 1'b0);

        // Start while busy is ignored; start during DONE chains with no gap.
        issue(16'd1000, 8'd7, 0);
        repeat (3) @(negedge clk);
        poke(16'd5, 8'd1);
        wait_done(40, nw, nb);
        lit("hs_1000_7", 16'h008E, 8'h06, 1'b0);
        issue(16'd9, 8'd2, 1);
        wait_done(40, nw, nb);
        lit("hs_9_2", 16'h0004, 8'h01, 1'b0);
        check("hs_b2b_latency", nw, LAT + 1);

        // Asynchronous reset in the middle of an operation.
        issue(16'hC350, 8'hC8, 0);
        acc = exp_q[0].acc;
        for (int i = 0; i < 40 && cyc < acc + 8; i++) @(negedge clk);
        #2;
        exp_q.delete();
        last_q = '0;
        last_r = '0;
        last_z = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_done", 32'(done), 32'(0));
        lit("mid_rst", 16'h0000, 8'h00, 1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        issue(16'd100, 8'd10, 0);
        wait_done(40, nw, nb);
        lit("100_10", 16'h000A, 8'h00, 1'b0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/n_bit_divider.md
Name: n_bit_divider

Overview:
- Sequential restoring divider. It reverses the team's combinational 8x8 array multiplier: it takes a 2N-bit product-width dividend and an N-bit divisor, and returns a 2N-bit quotient and an N-bit remainder.
- Computes one quotient bit per clock with a start/done handshake.
- Sits beside the multiplier in the arithmetic datapath of the course FPGA design.

Parameters:
- N, 8, divisor and remainder width. Dividend and quotient are 2N bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- dividend  input  2N  numerator; latched on an accepted start.
- divisor  input  N  denominator; latched on an accepted start.
- busy  output  1  high while in RUN (and FIX when signed mode is compiled in).
- done  output  1  one-cycle pulse; results are valid in that cycle.
- quotient  output  2N  result; held until the next completion.
- remainder  output  N  result; held until the next completion.
- div_by_zero  output  1  set with done when the latched divisor was 0.

Behaviour:
- Reset (async, active-high):
  - state = IDLE.
  - busy, done, div_by_zero = 0; quotient = 0; remainder = 0.
  - Internal count and working registers = 0.
  - Reset in any state aborts the operation; no done is produced.
- States: IDLE, RUN, DONE (plus FIX with the optional feature).
- IDLE or DONE with start = 1 at edge E0:
  - Latch the operands.
  - Divisor != 0: go to RUN, busy = 1, count = 2N, partial remainder (N+1 bits) = 0, shift register = dividend.
  - Divisor == 0: go straight to DONE. quotient = all ones (0xFFFF for N=8), remainder = 0, div_by_zero = 1. done is high in the cycle after E0.
- RUN, each edge (one iteration):
  - Shift {partial remainder, shift register} left by 1.
  - Trial = partial remainder - {1'b0, divisor}.
  - Trial non-negative: partial remainder = trial, shift LSB = 1. Otherwise restore and shift LSB = 0.
  - count decrements by 1.
- Iterations occur on edges E1..E2N. At E2N:
  - Go to DONE, busy = 0.
  - quotient = shift register, remainder = partial remainder[N-1:0], div_by_zero = 0.
  - done is high in the cycle after E2N. Latency: 2N+1 edges from start to the done cycle (17 for N=8).
- DONE:
  - done = 1 for exactly one cycle.
  - Next edge: start = 1 begins a new operation (back-to-back, no idle cycle); otherwise go to IDLE.
- start while busy: ignored; operands are not re-latched.
- Operand inputs may change freely after the accepting edge.
- quotient, remainder and div_by_zero hold their values through IDLE and RUN until the next DONE entry.
- Unsigned arithmetic only (without the option). Remainder < divisor always.
- dividend = quotient*divisor + remainder, exactly, mod 2^(2N).

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined:
  - Operands are two's complement.
  - Magnitudes enter RUN.
  - After the last iteration, the FSM spends one extra FIX cycle (busy still 1) applying signs:
    - quotient negated if the operand signs differ (truncation toward zero);
    - remainder takes the sign of the dividend.
  - Latency becomes 2N+2 edges.
  - Overflow case (-2^(2N-1) / -1): quotient wraps to 0x8000, remainder 0, no flag.
  - Divide-by-zero behaviour unchanged.
- Undefined: pure unsigned, no FIX state.

Test Plan:
- Unsigned operations:
  - 0xC350 / 0xC8 -> quotient 0x00FA, remainder 0x00, div_by_zero 0.
  - Same test: busy high exactly 16 cycles; done one cycle, 17 edges after start.
- Edge values:
  - 1000 / 7 -> quotient 0x008E, remainder 0x06.
  - 0xFFFF / 0x01 -> quotient 0xFFFF, remainder 0x00.
  - 0x00FE / 0xFF -> quotient 0x0000, remainder 0xFE.
- Divide by zero:
  - 0x04D2 / 0x00 -> done the cycle after start, quotient 0xFFFF, remainder 0x00, div_by_zero 1.
  - Next op 10 / 3 -> quotient 0x0003, remainder 0x01, div_by_zero 0.
- Handshake:
  - start 1000/7 (quotient 0x008E, remainder 0x06).
  - Pulse start with 5/1 at cycle 5 -> ignored; result still 0x008E/0x06.
  - start held during DONE with 9/2 -> new op accepted with no gap, quotient 0x0004, remainder 0x01.
- Reset mid-operation:
  - Assert reset at RUN iteration 8 of 0xC350/0xC8 -> all outputs 0 immediately (async), no done.
  - After release, 100/10 -> quotient 0x000A, remainder 0x00.
- Signed (DIV_SIGNED_EN only):
  - -1000 / 7 -> quotient 0xFF72, remainder 0xFA.
  - 1000 / -7 -> quotient 0xFF72, remainder 0x06.
  - 0x8000 / 0xFF -> quotient 0x8000, remainder 0x00.
  - All three: 18-edge latency.
